ps2_scancode_rx: RTL and testbench

Upstream stage of the PS/2-to-ASCII lookup. Receives raw PS/2 keyboard frames on the ps2_clk/ps2_data pins and validates framing. Strips the F0 (break) and E0 (extended) prefixes. Presents the currently held make code on ps2_out, which feeds the scan-code-to-ASCII table; ps2_out reads 8'h00 when no key is held, so the table outputs ASCII 0.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_frame_rx.sv | 121 ++++++++++++
 rtl/ps2_scancode_rx.sv | 87 ++++++++
 tb/tb_ps2_scancode_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0]  PS2_BREAK     = 8'hF0;
  localparam logic [7:0]  PS2_EXT       = 8'hE0;
  localparam int unsigned PS2_DATA_BITS = 8;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame FSM
// and inter-edge timeout. Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_frame_ok,
  output logic       o_frame_err
);

  logic [2:0]       r_clk_sync;
  logic [1:0]       r_dat_sync;
  ps2_state_e       r_state, w_state_d;
  logic [2:0]       r_bit_cnt, w_bit_cnt_d;
  logic [7:0]       r_shift, w_shift_d;
  logic             r_par, w_par_d;
  logic [CNT_W-1:0] r_tcnt, w_tcnt_d;

  logic w_fall;
  logic w_bit;
  logic w_timeout;
  logic w_frame_good;

  // [0],[1] form the two-flop synchronizer; [2] is the previous sample for edge detect.
  assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_bit  = r_dat_sync[1];
  assign o_byte = r_shift;

  // Synchronizers reset to the idle-bus level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_sync <= 3'b111;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
    end
  end

  // Frame state, bit counter, shift register, parity latch and timeout counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      r_state   <= w_state_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shift   <= w_shift_d;
      r_par     <= w_par_d;
      r_tcnt    <= w_tcnt_d;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign w_frame_good = w_bit & odd_parity_ok(r_shift, r_par);
`else
  assign w_frame_good = w_bit;
`endif

  // A falling edge in the same cycle as the limit counts as activity, not a timeout.
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and frame result decode.
  always_comb begin
    w_state_d   = r_state;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_par_d     = r_par;
    w_tcnt_d    = w_fall ? '0 : r_tcnt + CNT_W'(1);
    o_frame_ok  = 1'b0;
    o_frame_err = 1'b0;
    if (w_timeout) begin
      w_state_d   = IDLE;
      w_shift_d   = '0;
      w_tcnt_d    = '0;
      o_frame_err = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_tcnt_d = '0;
          if (w_fall && !w_bit) begin
            w_state_d   = DATA;
            w_bit_cnt_d = '0;
          end
        end
        DATA: begin
          if (w_fall) begin
            w_shift_d   = {w_bit, r_shift[7:1]};
            w_bit_cnt_d = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) w_state_d = PARITY;
          end
        end
        PARITY: begin
          if (w_fall) begin
            w_par_d   = w_bit;
            w_state_d = STOP;
          end
        end
        STOP: begin
          if (w_fall) begin
            w_state_d = IDLE;
            if (w_frame_good) o_frame_ok = 1'b1;
            else              o_frame_err = 1'b1;
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 scan-code receiver top: strips F0/E0 prefixes and holds the current make code.
// Optional parity checking in the frame receiver: PS2_PARITY_CHECK_EN.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_out,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] w_byte;
  logic       w_frame_ok;
  logic       w_frame_err;

  logic [7:0] r_out, w_out_d;
  logic       r_key_valid, w_key_valid_d;
  logic       r_frame_err;
  logic       r_brk, w_brk_d;
  logic       r_ext, w_ext_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_frame_rx (
    .clock      (clock),
    .reset      (reset),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_byte     (w_byte),
    .o_frame_ok (w_frame_ok),
    .o_frame_err(w_frame_err)
  );

  // Prefix decoder: break consumes the next byte; extended codes are dropped so they
  // never alias keypad make codes.
  always_comb begin
    w_out_d       = r_out;
    w_key_valid_d = 1'b0;
    w_brk_d       = r_brk;
    w_ext_d       = r_ext;
    if (w_frame_ok) begin
      if (w_byte == PS2_BREAK) begin
        w_brk_d = 1'b1;
      end else if (w_byte == PS2_EXT) begin
        w_ext_d = 1'b1;
      end else if (r_brk) begin
        w_brk_d = 1'b0;
        w_ext_d = 1'b0;
        if (w_byte == r_out) w_out_d = 8'h00;
      end else if (r_ext) begin
        w_ext_d = 1'b0;
      end else begin
        w_out_d       = w_byte;
        w_key_valid_d = 1'b1;
      end
    end
  end

  // Output and prefix-flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out       <= 8'h00;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
    end else begin
      r_out       <= w_out_d;
      r_key_valid <= w_key_valid_d;
      r_frame_err <= w_frame_err;
      r_brk       <= w_brk_d;
      r_ext       <= w_ext_d;
    end
  end

  assign ps2_out   = r_out;
  assign key_valid = r_key_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: directed test-plan steps followed by
// random frames, checked against a byte-level keyboard-protocol model.
module tb_ps2_scancode_rx;

  localparam int unsigned TO = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_out;
  logic       key_valid;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;

  // Model state
  logic [7:0] m_out = 8'h00;
  logic       m_brk = 1'b0;
  logic       m_ext = 1'b0;
  int         m_kv  = 0;
  int         m_fe  = 0;

  ps2_scancode_rx #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_out  (ps2_out),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  // Pulse counters; the two pulses must never coincide.
  always @(negedge clock) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
    if (key_valid || frame_err) begin
      checks++;
      assert (!(key_valid && frame_err)) else begin
        errors++;
        $error("FAIL pulse_overlap observed key_valid=%0b frame_err=%0b expected not both",
               key_valid, frame_err);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive n bits LSB first, one PS/2 clock period per bit, bus left idle.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_clk(10);
      ps2_clk = 1'b0;
      wait_clk(20);
      ps2_clk = 1'b1;
      wait_clk(10);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop);
    logic par;
    par = (~^b) ^ par_bad;
    send_bits({stop, par, b, 1'b0}, 11);
    wait_clk(10);
  endtask

  // Keyboard-protocol model at byte level.
  task automatic model_frame(input logic [7:0] b, input logic par_bad, input logic stop);
    logic accept;
    accept = stop;
`ifdef PS2_PARITY_CHECK_EN
    if (par_bad) accept = 1'b0;
`endif
    if (!accept) m_fe++;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (m_brk) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
      if (b == m_out) m_out = 8'h00;
    end else if (m_ext) m_ext = 1'b0;
    else begin
      m_out = b;
      m_kv++;
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic par_bad, input logic stop);
    send_frame(b, par_bad, stop);
    model_frame(b, par_bad, stop);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_out"}, {24'h0, ps2_out}, {24'h0, m_out});
    check({tag, "_kv"}, kv_cnt, m_kv);
    check({tag, "_fe"}, fe_cnt, m_fe);
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    int         r;

    wait_clk(4);
    check("rst_out", {24'h0, ps2_out}, 32'h0);
    check("rst_kv", {31'h0, key_valid}, 32'h0);
    check("rst_fe", {31'h0, frame_err}, 32'h0);
    reset = 1'b0;
    wait_clk(4);

    // 1: plain make
    frame(8'h1C, 1'b0, 1'b1);
    check_all("make1c");
    check("make1c_lit", {24'h0, ps2_out}, 32'h1C);

    // 2: break of held key
    frame(8'hF0, 1'b0, 1'b1);
    frame(8'h1C, 1'b0, 1'b1);
    check_all("brk1c");
    check("brk1c_lit", {24'h0, ps2_out}, 32'h00);

    // 3: break of a different key, then typematic repeat
    frame(8'h45, 1'b0, 1'b1);
    frame(8'hF0, 1'b0, 1'b1);
    frame(8'h16, 1'b0, 1'b1);
    check_all("brk16");
    frame(8'h45, 1'b0, 1'b1);
    check_all("rep45");

    // 4: extended code dropped, plain code accepted
    frame(8'hE0, 1'b0, 1'b1);
    frame(8'h75, 1'b0, 1'b1);
    check_all("ext75");
    frame(8'h75, 1'b0, 1'b1);
    check_all("make75");

    // 5: bad parity
    frame(8'h45, 1'b1, 1'b1);
    check_all("par45");

    // Bad stop bit
    frame(8'h33, 1'b0, 1'b0);
    check_all("stop33");

    // 6a: timeout mid-frame, then a full frame
    send_bits(11'b000_0000_1010, 5);
    wait_clk(TO + 5);
    m_fe++;
    check_all("tmo");
    frame(8'h16, 1'b0, 1'b1);
    check_all("post_tmo");

    // 6b: reset mid-frame
    send_bits(11'b000_0001_0110, 4);
    reset = 1'b1;
    wait_clk(3);
    check("rstmid_out", {24'h0, ps2_out}, 32'h0);
    check("rstmid_kv", {31'h0, key_valid}, 32'h0);
    check("rstmid_fe", {31'h0, frame_err}, 32'h0);
    reset = 1'b0;
    m_out = 8'h00;
    m_brk = 1'b0;
    m_ext = 1'b0;
    wait_clk(4);
    frame(8'h2B, 1'b0, 1'b1);
    check_all("post_rst");

    // Random traffic
    for (int i = 0; i < 50; i++) begin
      r = int'($urandom_range(0, 15));
      if (r < 3)       b = 8'hF0;
      else if (r < 5)  b = 8'hE0;
      else if (r < 7)  b = m_out;
      else             b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 15) != 0);
      frame(b, 1'b0, stop);
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #5ms;
    $display("FAIL timeout observed=stuck expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
